pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Turns a stage boundary into an elastic register: valid/ready handshake, global stall, synchronous flush, bubble/NOP injection and saturating performance counters.
- One instance per stage boundary in the 5-stage core. DATA_W covers the whole stage bundle (PC, instruction, control, operands).

---
 rtl/pipe_pkg.sv | 11 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline stage register and its counters.
package pipe_pkg;

    localparam logic [31:0] RV32_NOP      = 32'h0000_0013;
    localparam int          CNT_W_DEFAULT = 32;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-high clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         async_rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic stage-boundary register with stall, flush, bubble fill and perf counters.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {{(DATA_W-32){1'b0}}, RV32_NOP},
    parameter int                 CNT_W     = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              en,
    input  logic              sync_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_main_v;
    logic [DATA_W-1:0] r_main_d;
    logic              w_skid_v;
    logic              w_in_fire;
    logic              w_out_fire;

    assign out_valid  = en & r_main_v;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    // r_main_d is reloaded with NOP_VALUE whenever the entry empties, so it can drive out_data directly.
    assign out_data   = r_main_d;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_v;
    logic [DATA_W-1:0] r_skid_d;

    assign w_skid_v = r_skid_v;
    assign in_ready = ~async_rst & en & ~r_skid_v;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_main_v <= 1'b0;
            r_main_d <= NOP_VALUE;
            r_skid_v <= 1'b0;
            r_skid_d <= NOP_VALUE;
        end else if (sync_rst) begin
            r_main_v <= 1'b0;
            r_main_d <= NOP_VALUE;
            r_skid_v <= 1'b0;
            r_skid_d <= NOP_VALUE;
        end else if (en) begin
            if (w_out_fire) begin
                if (r_skid_v) begin
                    r_main_v <= 1'b1;
                    r_main_d <= r_skid_d;
                    if (w_in_fire) begin
                        r_skid_d <= in_data;
                    end else begin
                        r_skid_v <= 1'b0;
                        r_skid_d <= NOP_VALUE;
                    end
                end else if (w_in_fire) begin
                    r_main_d <= in_data;
                end else begin
                    r_main_v <= 1'b0;
                    r_main_d <= NOP_VALUE;
                end
            end else if (w_in_fire) begin
                // Main is blocked downstream: park the newcomer behind it.
                if (r_main_v) begin
                    r_skid_v <= 1'b1;
                    r_skid_d <= in_data;
                end else begin
                    r_main_v <= 1'b1;
                    r_main_d <= in_data;
                end
            end
        end
    end
`else
    assign w_skid_v = 1'b0;
    assign in_ready = ~async_rst & en & (~r_main_v | out_ready);

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_main_v <= 1'b0;
            r_main_d <= NOP_VALUE;
        end else if (sync_rst) begin
            r_main_v <= 1'b0;
            r_main_d <= NOP_VALUE;
        end else if (en) begin
            if (w_in_fire) begin
                r_main_v <= 1'b1;
                r_main_d <= in_data;
            end else if (w_out_fire) begin
                r_main_v <= 1'b0;
                r_main_d <= NOP_VALUE;
            end
        end
    end
`endif

    always_comb begin
        occupancy = OCC_EMPTY;
        case ({w_skid_v, r_main_v})
            2'b01:   occupancy = OCC_ONE;
            2'b11:   occupancy = OCC_FULL;
            2'b10:   occupancy = OCC_ONE;
            default: occupancy = OCC_EMPTY;
        endcase
    end

    // Counter slots: 0 = stall, 1 = bubble, 2 = flush.
    logic [2:0]       w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_val [3];

    assign w_cnt_inc[0] = en & r_main_v & ~out_ready;
    assign w_cnt_inc[1] = en & ~r_main_v;
    assign w_cnt_inc[2] = sync_rst;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            sat_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .async_rst (async_rst),
                .inc       (w_cnt_inc[gi]),
                .count     (w_cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt  = w_cnt_val[0];
    assign bubble_cnt = w_cnt_val[1];
    assign flush_cnt  = w_cnt_val[2];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; honours PIPE_STAGE_SKID_EN when it is defined.
module tb_pipe_stage_reg;

    localparam int DW = 64;
    localparam int CW = 4;
    localparam logic [DW-1:0] NOP = 64'h13;
`ifdef PIPE_STAGE_SKID_EN
    localparam int FULL_OCC = 2;
`else
    localparam int FULL_OCC = 1;
`endif

    logic          clk = 1'b0;
    logic          async_rst, en, sync_rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .async_rst  (async_rst),
        .en         (en),
        .sync_rst   (sync_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted bundles are queued, delivered bundles are popped and compared.
    always @(negedge clk) begin : sb
        logic [DW-1:0] e;
        if (async_rst || sync_rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("out %0h", out_data);
                    check("sb_data", out_data, e);
                end
            end
            if (en && !out_valid) check("nop_when_idle", out_data, NOP);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                $display("in  %0h", in_data);
            end
        end
    end

    initial begin
        async_rst = 1'b1; en = 1'b1; sync_rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Power-on reset
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, NOP);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        check("rst_flush", 64'(flush_cnt), 64'd0);
        async_rst = 1'b0;
        out_ready = 1'b1;

        // Streaming
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", out_data, 64'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain", 64'(out_valid), 64'd0);
        check("stream_stall", 64'(stall_cnt), 64'd0);

        // Backpressure
        in_valid = 1'b1; in_data = 64'h10;
        tick();
        out_ready = 1'b0; in_data = 64'h11;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_data", out_data, 64'h10);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_occ", 64'(occupancy), 64'(FULL_OCC));
        end
        check("bp_stall", 64'(stall_cnt), 64'd5);
        out_ready = 1'b1;
        in_valid  = (FULL_OCC == 1);
        tick();
        check("rel_data", out_data, 64'h11);
        check("rel_occ", 64'(occupancy), 64'd1);
        in_valid = 1'b0;
        tick();
        check("rel_drain", 64'(out_valid), 64'd0);
        check("rel_stall", 64'(stall_cnt), 64'd5);

        // Stall via en
        in_valid = 1'b1; in_data = 64'h20;
        tick();
        check("pre_stall_data", out_data, 64'h20);
        en = 1'b0; in_data = 64'h21;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_out_valid", 64'(out_valid), 64'd0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_hold", out_data, 64'h20);
            check("stall_occ", 64'(occupancy), 64'd1);
        end
        check("stall_no_cnt", 64'(stall_cnt), 64'd5);
        en = 1'b1;
        tick();
        check("resume_data", out_data, 64'h21);
        in_data = 64'h22;
        tick();
        check("resume_next", out_data, 64'h22);
        in_valid = 1'b0;
        tick();

        // Flush
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h30;
        tick();
        sync_rst = 1'b1; in_data = 64'hAB; out_ready = 1'b1;
        tick();
        sync_rst = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_data", out_data, NOP);
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_cnt", 64'(flush_cnt), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_quiet", 64'(out_valid), 64'd0);
        end

        // Reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h40;
        tick();
        in_valid = 1'b0;
        check("mid_valid", 64'(out_valid), 64'd1);
        async_rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", out_data, NOP);
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_stall", 64'(stall_cnt), 64'd0);
        check("mid_rst_bubble", 64'(bubble_cnt), 64'd0);
        check("mid_rst_flush", 64'(flush_cnt), 64'd0);
        tick();
        async_rst = 1'b0;

        // Saturation of the bubble counter
        out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) check("sat_14", 64'(bubble_cnt), 64'd14);
            if (k == 15) check("sat_15", 64'(bubble_cnt), 64'd15);
            if (k == 20) check("sat_hold", 64'(bubble_cnt), 64'd15);
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
